// File: rtl/mux4_rr_select.sv
// Round-robin arbiter driving the registered select of a 4:1 data mux, with a
// valid/ready handshake toward the consumer and bounded bursts per grant.
`timescale 1ns/1ps
module mux4_rr_select #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] s,
    output logic       out_valid,
    output logic [3:0] ack,
    output logic       busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state;
    logic [1:0]       last;
    logic [CNT_W-1:0] burst_cnt;

    // Scan from last+1 upward so the previous winner has lowest priority.
    function automatic logic [1:0] pick(input logic [1:0] l, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        pick  = l;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign busy      = (state == GRANT);
    assign out_valid = busy & req[s];
    assign ack       = (out_valid & out_ready) ? (4'b0001 << s) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= 2'd0;
            last      <= 2'd3;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        s         <= pick(last, req);
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Withdrawal ends the grant without a transfer; s stays put throughout.
                    if (!req[s]) begin
                        last  <= s;
                        state <= IDLE;
                    end else if (out_ready) begin
                        if (burst_cnt == CNT_LAST) begin
                            last  <= s;
                            state <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_select.sv
// Bench for mux4_rr_select: two instances (BURST_LEN 4 and 1) share random
// and directed stimulus and are compared every cycle to a transfer-level model.
`timescale 1ns/1ps
module tb_mux4_rr_select;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'h0;
    logic       out_ready = 1'b0;

    logic [1:0] s4, s1;
    logic       ov4, ov1, b4, b1;
    logic [3:0] a4, a1;

    int n_chk = 0;
    int n_fail = 0;

    // Model state per instance: owner = granted source or -1 when none.
    int blen[2] = '{4, 1};
    int owner[2];
    int remaining[2];
    int last[2];
    int es[2];

    always #5 clk = ~clk;

    mux4_rr_select #(.BURST_LEN(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .s(s4), .out_valid(ov4), .ack(a4), .busy(b4));

    mux4_rr_select #(.BURST_LEN(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .s(s1), .out_valid(ov1), .ack(a1), .busy(b1));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rr_pick(input int l, input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (r[(l + k) % 4]) return (l + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1;
            remaining[i] = 0;
            last[i] = 3;
            es[i] = 0;
        end
    endtask

    task automatic model_adv();
        for (int i = 0; i < 2; i++) begin
            if (owner[i] < 0) begin
                if (req != 4'h0) begin
                    owner[i] = rr_pick(last[i], req);
                    remaining[i] = blen[i];
                    es[i] = owner[i];
                end
            end else if (req[owner[i]]) begin
                if (out_ready) begin
                    remaining[i]--;
                    if (remaining[i] == 0) begin
                        last[i] = owner[i];
                        owner[i] = -1;
                    end
                end
            end else begin
                last[i] = owner[i];
                owner[i] = -1;
            end
        end
    endtask

    task automatic compare_model();
        logic [1:0] ds;
        logic       dov, db;
        logic [3:0] da, eack;
        logic       eov;
        for (int i = 0; i < 2; i++) begin
            ds  = (i == 0) ? s4 : s1;
            dov = (i == 0) ? ov4 : ov1;
            db  = (i == 0) ? b4 : b1;
            da  = (i == 0) ? a4 : a1;
            eov  = (owner[i] >= 0) && req[owner[i]];
            eack = (eov && out_ready) ? (4'b0001 << owner[i]) : 4'b0000;
            chk($sformatf("model_s[%0d]", i), 8'(ds), 8'(es[i]));
            chk($sformatf("model_busy[%0d]", i), 8'(db), 8'(owner[i] >= 0));
            chk($sformatf("model_valid[%0d]", i), 8'(dov), 8'(eov));
            chk($sformatf("model_ack[%0d]", i), 8'(da), 8'(eack));
        end
    endtask

    // Drive inputs mid-cycle, let comb outputs settle, compare against the model.
    task automatic drive(input logic [3:0] r, input logic rd);
        @(negedge clk);
        req = r;
        out_ready = rd;
        #1;
        compare_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_adv();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'hF;
        out_ready = 1'b1;
        #1;
        chk("rst_s", 8'(s4), 8'd0);
        chk("rst_valid", 8'(ov4), 8'd0);
        chk("rst_ack", 8'(a4), 8'd0);
        chk("rst_busy", 8'(b4), 8'd0);
        model_reset();
        @(negedge clk);
        req = 4'h0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        compare_model();
        adv();
    endtask

    initial begin
        logic [3:0] r;
        logic       rd;
        int         order[5] = '{0, 1, 2, 3, 0};
        model_reset();
        #12;
        do_reset();

        // Single source, full bursts with one bubble between grants.
        drive(4'b0100, 1'b1);
        chk("t2_c0_busy", 8'(b4), 8'd0);
        adv();
        for (int c = 1; c <= 4; c++) begin
            drive(4'b0100, 1'b1);
            chk("t2_s", 8'(s4), 8'd2);
            chk("t2_valid", 8'(ov4), 8'd1);
            chk("t2_ack", 8'(a4), 8'b0100);
            adv();
        end
        drive(4'b0100, 1'b1);
        chk("t2_c5_valid", 8'(ov4), 8'd0);
        chk("t2_c5_busy", 8'(b4), 8'd0);
        adv();
        drive(4'b0100, 1'b1);
        chk("t2_c6_s", 8'(s4), 8'd2);
        chk("t2_c6_busy", 8'(b4), 8'd1);
        adv();

        // BURST_LEN=1 with all four requesting: rotate 0,1,2,3,0.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(4'hF, 1'b1);
            if (k % 2 == 1) begin
                chk("t3_s", 8'(s1), 8'(order[k / 2]));
                chk("t3_ack", 8'(a1), 8'(4'b0001 << order[k / 2]));
            end else begin
                chk("t3_bubble_ack", 8'(a1), 8'd0);
                chk("t3_bubble_busy", 8'(b1), 8'd0);
            end
            adv();
        end

        // Backpressure holds the grant.
        do_reset();
        drive(4'b0010, 1'b0);
        adv();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, 1'b0);
            chk("t4_hold_s", 8'(s4), 8'd1);
            chk("t4_hold_valid", 8'(ov4), 8'd1);
            chk("t4_hold_ack", 8'(a4), 8'd0);
            adv();
        end
        drive(4'b0010, 1'b1);
        chk("t4_ack", 8'(a4), 8'b0010);
        adv();

        // Withdraw by source 3 hands over to source 0 after a bubble.
        do_reset();
        drive(4'b1000, 1'b0);
        adv();
        drive(4'b0001, 1'b0);
        chk("t5_valid", 8'(ov4), 8'd0);
        chk("t5_ack", 8'(a4), 8'd0);
        chk("t5_s", 8'(s4), 8'd3);
        adv();
        drive(4'b0001, 1'b0);
        chk("t5_idle_busy", 8'(b4), 8'd0);
        adv();
        drive(4'b0001, 1'b0);
        chk("t5_s0", 8'(s4), 8'd0);
        chk("t5_busy", 8'(b4), 8'd1);
        adv();

        // Async reset pulse in the middle of a burst.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0100, 1'b1);
            adv();
        end
        drive(4'b0100, 1'b1);
        chk("t6_pre_valid", 8'(ov4), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 8'(ov4), 8'd0);
        chk("t6_rst_ack", 8'(a4), 8'd0);
        model_reset();
        req = 4'b1001;
        rst_n = 1'b1;
        #1;
        adv();
        drive(4'b1001, 1'b1);
        chk("t6_first_s", 8'(s4), 8'd0);
        chk("t6_busy", 8'(b4), 8'd1);
        adv();

        // Random traffic with sticky requests and occasional resets.
        r = 4'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            if (n % 700 == 699) do_reset();
            drive(r, rd);
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
